// File: rtl/budget_arbiter_pkg.sv
// Shared definitions for the budget arbiter and the accumulate/margin datapath test.
package budget_arbiter_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_MAX_BUDGET    = 111;
    localparam int DEF_NREQ          = 4;
    localparam int DEF_REFILL_PERIOD = 16;

    // RUN arbitrates normally; REFILL is the single decision-free cycle before the pool restores.
    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } arb_state_t;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/budget_arbiter_rr_pick.sv
// Round-robin head finder: first set bit of mask at or after ptr, wrapping modulo NREQ.
module budget_arbiter_rr_pick
    import budget_arbiter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   head,
    output logic            valid
);

    logic [PW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            // Candidate at scan position gi is (ptr + gi) mod NREQ; one extra bit holds the carry.
            logic [PW:0] sum;
            assign sum          = {1'b0, ptr} + (PW + 1)'(gi);
            assign cand_idx[gi] = (sum >= (PW + 1)'(NREQ)) ? PW'(sum - (PW + 1)'(NREQ)) : PW'(sum);
            assign cand_hit[gi] = mask[cand_idx[gi]];
        end
    endgenerate

    // Priority scan over positions; iterating downward lets the closest position to ptr win.
    always_comb begin
        head  = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                head  = cand_idx[k];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/budget_arbiter.sv
// Budget arbiter: grants whole fixed-size requests round-robin from a shared pool that
// refills every REFILL_PERIOD cycles. Head-of-line blocking keeps large requests from starving.
module budget_arbiter
    import budget_arbiter_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int MAX_BUDGET    = DEF_MAX_BUDGET,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   amt,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         nack,
    output logic [WIDTH-1:0]        gnt_amt,
    output logic [WIDTH-1:0]        used,
    output logic [WIDTH-1:0]        margin,
    output logic                    refill
);

    localparam int               PW        = idx_width(NREQ);
    localparam int               TW        = idx_width(REFILL_PERIOD);
    localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_BUDGET);
    localparam logic [TW-1:0]    TIMER_PRE = TW'(REFILL_PERIOD - 2);

    arb_state_t       state_reg;
    logic [TW-1:0]    timer_reg;
    logic [PW-1:0]    ptr_reg;
    logic [WIDTH-1:0] used_reg;
    logic [WIDTH-1:0] margin_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic [NREQ-1:0]  nack_reg;
    logic [WIDTH-1:0] gnt_amt_reg;
    logic             refill_reg;

    logic [NREQ-1:0]  req_mask;
    logic [PW-1:0]    head;
    logic             head_valid;
    logic [WIDTH-1:0] head_amt;
    logic [NREQ-1:0]  head_onehot;
    logic [PW-1:0]    ptr_next;
    logic             gnt_next;
    logic             nack_next;

    // A requester still shown a gnt/nack pulse is holding a request that has already been served.
    assign req_mask = req & ~gnt_reg & ~nack_reg;

    budget_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .mask  (req_mask),
        .ptr   (ptr_reg),
        .head  (head),
        .valid (head_valid)
    );

    // Decide the head's fate: oversize requests are rejected, fitting ones granted, others wait.
    always_comb begin
        head_amt    = amt[int'(head) * WIDTH +: WIDTH];
        head_onehot = {{(NREQ - 1){1'b0}}, 1'b1} << head;
        ptr_next    = (head == PW'(NREQ - 1)) ? '0 : head + 1'b1;
        gnt_next    = 1'b0;
        nack_next   = 1'b0;
        if (state_reg == RUN && head_valid) begin
            if (head_amt > MAX_W) begin
                nack_next = 1'b1;
            end else if (head_amt <= margin_reg) begin
                gnt_next = 1'b1;
            end
        end
    end

    // Control FSM, refill timer, budget counters and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= RUN;
            timer_reg   <= '0;
            ptr_reg     <= '0;
            used_reg    <= '0;
            margin_reg  <= MAX_W;
            gnt_reg     <= '0;
            nack_reg    <= '0;
            gnt_amt_reg <= '0;
            refill_reg  <= 1'b0;
        end else begin
            gnt_reg     <= '0;
            nack_reg    <= '0;
            gnt_amt_reg <= '0;
            refill_reg  <= 1'b0;
            case (state_reg)
                RUN: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (timer_reg == TIMER_PRE) begin
                        state_reg <= REFILL;
                    end
                    if (gnt_next) begin
                        gnt_reg     <= head_onehot;
                        gnt_amt_reg <= head_amt;
                        used_reg    <= used_reg + head_amt;
                        margin_reg  <= margin_reg - head_amt;
                        ptr_reg     <= ptr_next;
                    end else if (nack_next) begin
                        nack_reg <= head_onehot;
                        ptr_reg  <= ptr_next;
                    end
                end
                REFILL: begin
                    timer_reg  <= '0;
                    used_reg   <= '0;
                    margin_reg <= MAX_W;
                    refill_reg <= 1'b1;
                    state_reg  <= RUN;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign nack    = nack_reg;
    assign gnt_amt = gnt_amt_reg;
    assign used    = used_reg;
    assign margin  = margin_reg;
    assign refill  = refill_reg;

`ifdef FORMAL
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_env
            // A pending request keeps req and amt steady until it has been answered.
            assume property (@(posedge clk) disable iff (!resetn)
                (req[gi] && !gnt[gi] && !nack[gi]) |=>
                    (req[gi] && $stable(amt[gi * WIDTH +: WIDTH])));
        end
    endgenerate

    // Pool conservation and pulse exclusivity.
    assert property (@(posedge clk) disable iff (!resetn)
        ({1'b0, used} + {1'b0, margin}) == (WIDTH + 1)'(MAX_BUDGET));
    assert property (@(posedge clk) disable iff (!resetn) used <= MAX_W);
    assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (!resetn) $onehot0(nack));
    assert property (@(posedge clk) disable iff (!resetn) (gnt & nack) == '0);
    assert property (@(posedge clk) disable iff (!resetn) (gnt == '0) |-> (gnt_amt == '0));

    cover property (@(posedge clk) disable iff (!resetn) used == MAX_W);
    cover property (@(posedge clk) disable iff (!resetn) refill ##1 (gnt != '0));
    cover property (@(posedge clk) disable iff (!resetn) nack != '0);
`endif

endmodule

// File: tb/tb_budget_arbiter.sv
// Directed bench for budget_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for fairness and mid-run reset.
module tb_budget_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int NVEC  = 34;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] amt;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       nack;
    logic [WIDTH-1:0]      gnt_amt;
    logic [WIDTH-1:0]      used;
    logic [WIDTH-1:0]      margin;
    logic                  refill;

    int n_checks = 0;
    int n_errors = 0;

    budget_arbiter #(
        .NREQ          (NREQ),
        .WIDTH         (WIDTH),
        .MAX_BUDGET    (111),
        .REFILL_PERIOD (16)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .amt     (amt),
        .gnt     (gnt),
        .nack    (nack),
        .gnt_amt (gnt_amt),
        .used    (used),
        .margin  (margin),
        .refill  (refill)
    );

    always #5 clk = ~clk;

    // Inputs applied in window k; expected outputs seen in window k+1.
    typedef struct {
        logic [3:0]  req;
        logic [31:0] amt;
        logic [3:0]  gnt;
        logic [3:0]  nack;
        logic [7:0]  gamt;
        logic [7:0]  used;
        logic [7:0]  margin;
        logic        refill;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_row(input int k, input logic [3:0] r, input logic [31:0] a,
                           input logic [3:0] g, input logic [3:0] n, input logic [7:0] ga,
                           input logic [7:0] u, input logic [7:0] m, input logic rf,
                           input logic [1:0] p);
        vecs[k].req    = r;
        vecs[k].amt    = a;
        vecs[k].gnt    = g;
        vecs[k].nack   = n;
        vecs[k].gamt   = ga;
        vecs[k].used   = u;
        vecs[k].margin = m;
        vecs[k].refill = rf;
        vecs[k].ptr    = p;
    endtask

    // Hold reset for two edges, check the reset state, and release; caller is then in window 0.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        req    = '0;
        amt    = '0;
        step();
        step();
        check({tag, "_gnt"},    32'(gnt),            0);
        check({tag, "_nack"},   32'(nack),           0);
        check({tag, "_gamt"},   32'(gnt_amt),        0);
        check({tag, "_used"},   32'(used),           0);
        check({tag, "_margin"}, 32'(margin),         111);
        check({tag, "_refill"}, 32'(refill),         0);
        check({tag, "_ptr"},    32'(dut.ptr_reg),    0);
        check({tag, "_timer"},  32'(dut.timer_reg),  0);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] a40;
        logic [31:0] a10;
        logic [3:0]  exp_g;
        a40 = {8'd112, 8'd40, 8'd40, 8'd40};
        a10 = {8'd112, 8'd40, 8'd40, 8'd10};

        // ---- vector table: overflow wait, refill, oversize nack, refill collision ----
        set_row(0,  4'b0111, a40, 4'b0001, 4'b0000, 8'd40, 8'd40, 8'd71,  1'b0, 2'd1);
        set_row(1,  4'b0111, a40, 4'b0010, 4'b0000, 8'd40, 8'd80, 8'd31,  1'b0, 2'd2);
        set_row(2,  4'b0110, a40, 4'b0000, 4'b0000, 8'd0,  8'd80, 8'd31,  1'b0, 2'd2);
        for (int k = 3; k <= 14; k++)
            set_row(k, 4'b0100, a40, 4'b0000, 4'b0000, 8'd0, 8'd80, 8'd31, 1'b0, 2'd2);
        set_row(15, 4'b0100, a40, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd111, 1'b1, 2'd2);
        set_row(16, 4'b0100, a40, 4'b0100, 4'b0000, 8'd40, 8'd40, 8'd71,  1'b0, 2'd3);
        set_row(17, 4'b0100, a40, 4'b0000, 4'b0000, 8'd0,  8'd40, 8'd71,  1'b0, 2'd3);
        set_row(18, 4'b1000, a40, 4'b0000, 4'b1000, 8'd0,  8'd40, 8'd71,  1'b0, 2'd0);
        set_row(19, 4'b1000, a40, 4'b0000, 4'b0000, 8'd0,  8'd40, 8'd71,  1'b0, 2'd0);
        for (int k = 20; k <= 30; k++)
            set_row(k, 4'b0000, a40, 4'b0000, 4'b0000, 8'd0, 8'd40, 8'd71, 1'b0, 2'd0);
        set_row(31, 4'b0001, a10, 4'b0000, 4'b0000, 8'd0,  8'd0,  8'd111, 1'b1, 2'd0);
        set_row(32, 4'b0001, a10, 4'b0001, 4'b0000, 8'd10, 8'd10, 8'd101, 1'b0, 2'd1);
        set_row(33, 4'b0001, a10, 4'b0000, 4'b0000, 8'd0,  8'd10, 8'd101, 1'b0, 2'd1);

        resetn = 1'b0;
        req    = '0;
        amt    = '0;
        do_reset("rst0");

        for (int k = 0; k < NVEC; k++) begin
            req = vecs[k].req;
            amt = vecs[k].amt;
            step();
            $display("vec %0d req=%b gnt=%b nack=%b gnt_amt=%0d used=%0d margin=%0d refill=%0d",
                     k, vecs[k].req, gnt, nack, gnt_amt, used, margin, refill);
            check($sformatf("v%0d_gnt", k),    32'(gnt),         32'(vecs[k].gnt));
            check($sformatf("v%0d_nack", k),   32'(nack),        32'(vecs[k].nack));
            check($sformatf("v%0d_gamt", k),   32'(gnt_amt),     32'(vecs[k].gamt));
            check($sformatf("v%0d_used", k),   32'(used),        32'(vecs[k].used));
            check($sformatf("v%0d_margin", k), 32'(margin),      32'(vecs[k].margin));
            check($sformatf("v%0d_refill", k), 32'(refill),      32'(vecs[k].refill));
            check($sformatf("v%0d_ptr", k),    32'(dut.ptr_reg), 32'(vecs[k].ptr));
        end

        // ---- fairness: all four ask 10 continuously -> 0,1,2,3,0,... until the pool runs dry ----
        do_reset("rst1");
        req = 4'b1111;
        amt = {8'd10, 8'd10, 8'd10, 8'd10};
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_g = 4'b0001 << ((k - 1) % 4);
            $display("fair %0d gnt=%b used=%0d margin=%0d", k, gnt, used, margin);
            check($sformatf("fair%0d_gnt", k),    32'(gnt),     32'(exp_g));
            check($sformatf("fair%0d_gamt", k),   32'(gnt_amt), 10);
            check($sformatf("fair%0d_used", k),   32'(used),    32'(10 * k));
            check($sformatf("fair%0d_margin", k), 32'(margin),  32'(111 - 10 * k));
        end
        step();
        $display("fair 12 gnt=%b used=%0d margin=%0d", gnt, used, margin);
        check("fair12_gnt",  32'(gnt),  0);
        check("fair12_used", 32'(used), 110);

        // ---- reset mid-run at used=80 ----
        do_reset("rst2");
        req = 4'b0011;
        amt = {8'd0, 8'd0, 8'd40, 8'd40};
        step();
        step();
        $display("mid used=%0d margin=%0d gnt=%b", used, margin, gnt);
        check("mid_used_pre",   32'(used),   80);
        check("mid_margin_pre", 32'(margin), 31);
        resetn = 1'b0;
        step();
        $display("mid-reset used=%0d margin=%0d gnt=%b", used, margin, gnt);
        check("midrst_used",   32'(used),           0);
        check("midrst_margin", 32'(margin),         111);
        check("midrst_gnt",    32'(gnt),            0);
        check("midrst_ptr",    32'(dut.ptr_reg),    0);
        check("midrst_timer",  32'(dut.timer_reg),  0);
        resetn = 1'b1;
        step();
        $display("post-reset gnt=%b used=%0d", gnt, used);
        check("postrst_gnt",  32'(gnt),  1);
        check("postrst_used", 32'(used), 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
